// File: rtl/serial_pkg.sv
// Shared definitions for the serial link (transmitter and receiver).
package serial_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } sipo_state_t;

endpackage

// File: rtl/serial_to_parallel_if.sv
// Word-level and serial-side signals of the receive end, grouped as one bus.
interface serial_to_parallel_if #(
    parameter int N = 4
);
    logic         EN;
    logic         start;
    logic         shift;
    logic         S;
    logic         ack;
    logic         clr_ovr;
    logic [N-1:0] Q;
    logic         valid;
    logic         busy;
    logic         overrun;

    modport master (
        output EN, start, shift, S, ack, clr_ovr,
        input  Q, valid, busy, overrun
    );

    modport slave (
        input  EN, start, shift, S, ack, clr_ovr,
        output Q, valid, busy, overrun
    );
endinterface

// File: rtl/serial_to_parallel_shift_reg.sv
// N-bit right-shift register; new bits enter at the MSB so the first bit ends up in bit 0.
module sipo_shift_reg #(
    parameter int N = 4
) (
    input  logic         CLK,
    input  logic         n_Reset,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [N-1:0] q
);

    always_ff @(posedge CLK or negedge n_Reset) begin
        if (!n_Reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {din, q[N-1:1]};
        end
    end

endmodule

// File: rtl/serial_to_parallel.sv
// Receive end of the serial link: rebuilds LSB-first N-bit words and hands them
// to the consumer through a valid/ack register with sticky overrun.
module serial_to_parallel
    import serial_pkg::*;
#(
    parameter int N = 4
) (
    input logic                 CLK,
    input logic                 n_Reset,
    serial_to_parallel_if.slave bus
);

    localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    sipo_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sr_clr;
    logic             sr_en;
    logic             done;
    logic [N-1:0]     sr;
    logic [N-1:0]     word;

    sipo_shift_reg #(.N(N)) u_sr (
        .CLK     (CLK),
        .n_Reset (n_Reset),
        .clr     (sr_clr),
        .en      (sr_en),
        .din     (bus.S),
        .q       (sr)
    );

    // The finished word includes the bit being sampled on this very edge.
    assign word = {bus.S, sr[N-1:1]};

    always_ff @(posedge CLK or negedge n_Reset) begin
        if (!n_Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_clr    = 1'b0;
        sr_en     = 1'b0;
        done      = 1'b0;
        if (bus.EN) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_nxt = RECV;
                        cnt_nxt   = '0;
                        sr_clr    = 1'b1;
                    end
                end
                RECV: begin
                    // start takes priority: the coinciding shift bit is discarded
                    if (bus.start) begin
                        cnt_nxt = '0;
                        sr_clr  = 1'b1;
                    end else if (bus.shift) begin
                        sr_en = 1'b1;
                        if (cnt == LAST) begin
                            done      = 1'b1;
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge n_Reset) begin
        if (!n_Reset) begin
            bus.Q       <= '0;
            bus.valid   <= 1'b0;
            bus.overrun <= 1'b0;
        end else begin
            if (done) begin
                if (!bus.valid || bus.ack) begin
                    bus.Q     <= word;
                    bus.valid <= 1'b1;
                end
            end else if (bus.ack) begin
                bus.valid <= 1'b0;
            end
            // A fresh overrun outranks a simultaneous clear.
            if (done && bus.valid && !bus.ack) begin
                bus.overrun <= 1'b1;
            end else if (bus.clr_ovr) begin
                bus.overrun <= 1'b0;
            end
        end
    end

    assign bus.busy = (state == RECV);

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel with N=4.
module tb_serial_to_parallel;

    logic CLK;
    logic n_Reset;
    int   total;
    int   bad;

    serial_to_parallel_if #(.N(4)) bus ();

    serial_to_parallel #(.N(4)) dut (
        .CLK     (CLK),
        .n_Reset (n_Reset),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.shift = 1'b1;
        bus.S     = b;
        tick();
        bus.shift = 1'b0;
        bus.S     = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_ack();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    // Bits listed in arrival order (LSB first).
    task automatic frame(input logic [3:0] w);
        do_start();
        for (int i = 0; i < 4; i++) send_bit(w[i]);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        n_Reset     = 1'b0;
        bus.EN      = 1'b1;
        bus.start   = 1'b0;
        bus.shift   = 1'b0;
        bus.S       = 1'b0;
        bus.ack     = 1'b0;
        bus.clr_ovr = 1'b0;
        #12;
        chk("rst_valid", 32'(bus.valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        n_Reset = 1'b1;
        tick();

        // Basic frame 1,0,1,1 -> D
        do_start();
        chk("basic_busy", 32'(bus.busy), 1);
        send_bit(1); send_bit(0); send_bit(1);
        chk("basic_valid_pre", 32'(bus.valid), 0);
        send_bit(1);
        chk("basic_q", 32'(bus.Q), 32'hD);
        chk("basic_valid", 32'(bus.valid), 1);
        chk("basic_busy_fall", 32'(bus.busy), 0);
        do_ack();
        chk("basic_ack", 32'(bus.valid), 0);

        // Back-to-back, ack coincides with the last bit of frame 2
        frame(4'hD);
        do_start();
        send_bit(0); send_bit(1); send_bit(0);
        bus.ack = 1'b1;
        send_bit(0);
        bus.ack = 1'b0;
        chk("b2b_q", 32'(bus.Q), 32'h2);
        chk("b2b_valid", 32'(bus.valid), 1);
        chk("b2b_ovr", 32'(bus.overrun), 0);
        do_ack();

        // Overrun: D unacked, then 6 dropped
        frame(4'hD);
        frame(4'h6);
        chk("ovr_q", 32'(bus.Q), 32'hD);
        chk("ovr_flag", 32'(bus.overrun), 1);
        chk("ovr_valid", 32'(bus.valid), 1);
        bus.clr_ovr = 1'b1;
        tick();
        bus.clr_ovr = 1'b0;
        chk("ovr_clr", 32'(bus.overrun), 0);

        // Set a new overrun, then reset mid-frame
        frame(4'h6);
        chk("ovr_again", 32'(bus.overrun), 1);
        do_start();
        send_bit(1);
        #2;
        n_Reset = 1'b0;
        #1;
        chk("midrst_q", 32'(bus.Q), 0);
        chk("midrst_valid", 32'(bus.valid), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_ovr", 32'(bus.overrun), 0);
        tick();
        n_Reset = 1'b1;
        tick();
        frame(4'h6);
        chk("postrst_q", 32'(bus.Q), 32'h6);
        chk("postrst_valid", 32'(bus.valid), 1);
        do_ack();

        // shift while idle is ignored
        send_bit(1);
        chk("idle_shift_busy", 32'(bus.busy), 0);
        chk("idle_shift_valid", 32'(bus.valid), 0);

        // Restart after 2 bits
        do_start();
        send_bit(1); send_bit(0);
        do_start();
        send_bit(1); send_bit(1); send_bit(1);
        chk("restart_pre", 32'(bus.valid), 0);
        send_bit(1);
        chk("restart_q", 32'(bus.Q), 32'hF);
        do_ack();

        // start and shift in the same cycle
        do_start();
        send_bit(1);
        bus.start = 1'b1;
        send_bit(0);
        bus.start = 1'b0;
        send_bit(1); send_bit(0); send_bit(0);
        chk("ss_pre", 32'(bus.valid), 0);
        send_bit(1);
        chk("ss_q", 32'(bus.Q), 32'h9);
        do_ack();

        // EN gating
        do_start();
        send_bit(1); send_bit(1);
        bus.EN = 1'b0;
        send_bit(0); send_bit(0);
        do_start();
        chk("en_busy", 32'(bus.busy), 1);
        bus.EN = 1'b1;
        send_bit(0);
        chk("en_pre", 32'(bus.valid), 0);
        send_bit(0);
        chk("en_q", 32'(bus.Q), 32'h3);
        chk("en_valid", 32'(bus.valid), 1);
        bus.EN = 1'b0;
        do_ack();
        chk("en_off_ack", 32'(bus.valid), 0);
        bus.EN = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
